// File: rtl/sel_cursor.sv
// sel_cursor: debounced 3x3 one-hot cursor and stretched X/O place strobe for the game core.
// Define SEL_WRAP_EN to make cursor moves wrap at the grid edges instead of saturating.
module sel_cursor #(
    parameter int DEB_CYCLES = 16,
    parameter int PULSE_LEN  = 4,
    parameter int HOLD_LEN   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic       x_turn,
    output logic [8:0] sel_pos,
    output logic       button_x,
    output logic       button_o,
    output logic       busy
);
    localparam int CW = $clog2((PULSE_LEN > HOLD_LEN ? PULSE_LEN : HOLD_LEN) + 1);
    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;
    logic [4:0] raw, sync1_q, sync2_q, stable_q, stable_d, evt;
    logic [15:0] deb_q [5];
    logic [15:0] deb_d [5];
    logic [1:0] row_q, row_d, col_q, col_d;
    logic [3:0] idx;
    logic [8:0] sel_d;
    logic mv_ok, turn_q, turn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t state_q, state_d;
    assign raw = {btn_place, btn_right, btn_left, btn_down, btn_up};
    // Bit order of raw/evt: 0 up, 1 down, 2 left, 3 right, 4 place.
    always_comb begin
        for (int b = 0; b < 5; b++) begin
            stable_d[b] = stable_q[b];
            deb_d[b]    = '0;
            evt[b]      = 1'b0;
            if (sync2_q[b] != stable_q[b]) begin
                if (deb_q[b] == 16'(DEB_CYCLES - 1)) begin
                    stable_d[b] = sync2_q[b];
                    evt[b]      = sync2_q[b];
                end else begin
                    deb_d[b] = deb_q[b] + 16'd1;
                end
            end
        end
    end
    function automatic logic [1:0] step(input logic [1:0] v, input logic dec, input logic inc);
`ifdef SEL_WRAP_EN
        return (dec && !inc) ? (v == 2'd0 ? 2'd2 : v - 2'd1) :
               (inc && !dec) ? (v == 2'd2 ? 2'd0 : v + 2'd1) : v;
`else
        return (dec && !inc) ? (v == 2'd0 ? v : v - 2'd1) :
               (inc && !dec) ? (v == 2'd2 ? v : v + 2'd1) : v;
`endif
    endfunction
    // A place event in the same cycle wins over any move.
    assign mv_ok = (state_q == IDLE) && !evt[4];
    assign row_d = mv_ok ? step(row_q, evt[0], evt[1]) : row_q;
    assign col_d = mv_ok ? step(col_q, evt[2], evt[3]) : col_q;
    assign idx   = 4'd8 - (4'd3 * {2'b00, row_d} + {2'b00, col_d});
    assign sel_d = 9'd1 << idx;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        turn_d  = turn_q;
        unique case (state_q)
            IDLE: if (evt[4]) begin
                state_d = PRESS;
                cnt_d   = CW'(PULSE_LEN - 1);
                turn_d  = x_turn;
            end
            PRESS: if (cnt_q == '0) begin
                state_d = HOLD;
                cnt_d   = CW'(HOLD_LEN - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            HOLD: if (cnt_q == '0) state_d = IDLE;
                  else cnt_d = cnt_q - CW'(1);
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int b = 0; b < 5; b++) deb_q[b] <= '0;
            row_q    <= 2'd1;
            col_q    <= 2'd1;
            sel_pos  <= 9'h010;
            state_q  <= IDLE;
            cnt_q    <= '0;
            turn_q   <= 1'b0;
            button_x <= 1'b0;
            button_o <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int b = 0; b < 5; b++) deb_q[b] <= deb_d[b];
            row_q    <= row_d;
            col_q    <= col_d;
            sel_pos  <= sel_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            turn_q   <= turn_d;
            button_x <= (state_d == PRESS) && turn_d;
            button_o <= (state_d == PRESS) && !turn_d;
            busy     <= state_d != IDLE;
        end
    end
endmodule

// File: doc/sel_cursor.md
Name: sel_cursor

Overview:
- Front-end input stage that sits directly upstream of the tic-tac-toe game core.
- Converts five raw push-buttons into a one-hot 3x3 cursor (sel_pos) and a stretched place strobe on button_x or button_o.
- The strobe is shaped so the game core's 4-bit edge detector reliably sees exactly one press.
- sel_pos is frozen for the duration of the strobe plus a guard window, so the core never samples a moving position.

Parameters:
- DEB_CYCLES, 16: consecutive identical synchronised samples required before a button's stable level changes; legal range 1..65535.
- PULSE_LEN, 4: cycles button_x/button_o is held high per placement; must be >= 3.
- HOLD_LEN, 4: guard cycles after the pulse during which sel_pos stays frozen and all button events are dropped; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw, asynchronous, active-high.
- btn_down  in  1  raw, asynchronous, active-high.
- btn_left  in  1  raw, asynchronous, active-high.
- btn_right  in  1  raw, asynchronous, active-high.
- btn_place  in  1  raw, asynchronous, active-high.
- x_turn  in  1  1 = X to move, 0 = O to move; sampled on the place event.
- sel_pos  out  9  one-hot cursor. Bit 8 = top-left, bit 6 = top-right, bit 0 = bottom-right; bit = 8 - (3*row + col), row/col 0 = top/left.
- button_x  out  1  place strobe for X.
- button_o  out  1  place strobe for O.
- busy  out  1  high while in PRESS or HOLD.

Behaviour:
- Reset (async, reset_n low):
  - row = 1, col = 1, so sel_pos = 9'b000010000.
  - button_x = button_o = busy = 0; FSM = IDLE.
  - All synchroniser flops, stable levels and debounce counters cleared to 0.
  - Takes effect immediately, including mid-PRESS; the strobe drops the same instant.
- Input conditioning, per button:
  - 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synchronised sample differs from the stable level and clears when they match.
  - On reaching DEB_CYCLES, the stable level flips and the counter clears.
  - Event = single-cycle pulse when the stable level goes 0 to 1. Releases generate no event.
  - Latency from a clean raw edge to the event: 2 + DEB_CYCLES cycles.
- Cursor, 2-bit row and col registers, range 0..2, updated only in IDLE:
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - Edge behaviour is set by SEL_WRAP_EN (see Optional Feature).
  - up+down events in the same cycle cancel, leaving row unchanged; likewise left+right for col.
  - A vertical and a horizontal event in the same cycle are both applied (diagonal move).
  - sel_pos is a registered decode of row/col and always has exactly one bit set.
- FSM:
  - IDLE:
    - A place event latches x_turn into turn_q, loads the counter with PULSE_LEN-1, and goes to PRESS.
    - A place event coincident with move events: the place wins, the placement uses the pre-move cursor, and the move events are discarded.
  - PRESS:
    - button_x = turn_q, button_o = ~turn_q; busy = 1.
    - Counter decrements each cycle; at 0, load HOLD_LEN-1 and go to HOLD.
    - Strobe width is exactly PULSE_LEN cycles.
  - HOLD:
    - Both strobes 0, busy = 1, sel_pos frozen.
    - At counter 0, go to IDLE.
  - In PRESS and HOLD, all events (moves and place) are dropped, not queued. Debouncers keep running.
- Outputs are glitch-free registers. button_x and button_o are never high together.
- The game core requires at least one low cycle before a strobe; the HOLD >= 1 rule guarantees this between back-to-back placements.

Optional Feature:
- Macro: SEL_WRAP_EN.
- Defined: moves wrap around the grid edges. up at row 0 goes to row 2; right at col 2 goes to col 0; and so on.
- Undefined: moves saturate at the edges. up at row 0 stays at row 0; right at col 2 stays at col 2. No other behaviour changes.

Test Plan:
- Reset, then idle for 50 cycles -> sel_pos = 9'h010, button_x = button_o = busy = 0 throughout.
- DEB_CYCLES = 4: btn_up pulsed high for 10 cycles, then btn_left high for 10 cycles -> sel_pos 9'h010 -> 9'h080 -> 9'h100. Each change occurs 6 cycles after the raw rising edge.
- Cursor at 9'h100, btn_up pressed -> SEL_WRAP_EN defined: 9'h004 (row 2, col 0). SEL_WRAP_EN undefined: stays 9'h100.
- x_turn = 1, btn_place pressed -> button_x high for exactly 4 cycles, button_o stays 0, busy high for 8 cycles. A btn_right press during busy leaves sel_pos unchanged after busy falls.
- x_turn = 0 with btn_place and btn_down debounce-complete in the same cycle -> button_o strobes for 4 cycles, and sel_pos stays at its pre-press value for the whole sequence and afterwards.
- reset_n asserted on the 2nd cycle of PRESS -> button_o/button_x and busy drop without waiting for a clock edge, sel_pos = 9'h010. After release, a new place event produces a full 4-cycle strobe.
